// File: rtl/regfile_pkg.sv
// Shared defaults and the reset-value rule for the register file scoreboard.
package regfile_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_ADDR_W   = 5;
    localparam int RF_ZERO_REG = 1;

    // Register i comes out of reset holding its own index; register 0 thereby
    // holds zero. Callers size-cast the result to their data width.
    function automatic logic [63:0] reset_value(input int unsigned idx);
        return 64'(idx);
    endfunction

endpackage

// File: rtl/busy_tracker.sv
// Busy-bit vector with registered population count.
// Clear is applied before set, so a same-cycle set of the same address wins.
module busy_tracker #(
    parameter int ADDR_W = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_addr,
    input  logic                   clr_en,
    input  logic [ADDR_W-1:0]      clr_addr,
    output logic [2**ADDR_W-1:0]   busy,
    output logic [ADDR_W:0]        count
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] busy_next;
    logic [ADDR_W:0]  count_next;

    // Next busy vector: clear first, then set, then count the result.
    always_comb begin
        busy_next = busy;
        if (clr_en) busy_next[clr_addr] = 1'b0;
        if (set_en) busy_next[set_addr] = 1'b1;
        count_next = '0;
        for (int i = 0; i < DEPTH; i++) begin
            count_next = count_next + (ADDR_W+1)'(busy_next[i]);
        end
    end

    // Busy bits and their count update together so the count is never stale.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy  <= '0;
            count <= '0;
        end else begin
            busy  <= busy_next;
            count <= count_next;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with per-register busy scoreboard and two registered read ports.
// Optional macro RF_BYPASS_EN: a read of the register being written back in the
// same cycle returns the writeback data instead of the pre-write contents.
// issue_valid and wb_valid are single-cycle strobes with no back-pressure: each
// cycle they are high is acted on at that rising edge (ignored during reset).
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = RF_ZERO_REG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_addr,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
`ifdef RF_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              set_en;
    logic              wr_en;
    logic              zero1, zero2;
    logic [DATA_W-1:0] rd_next1, rd_next2;
    logic              busy_next1, busy_next2;

    // Register 0 never becomes busy and never stores data when hardwired.
    assign set_en = issue_valid && !((ZERO_REG != 0) && (issue_addr == '0));
    assign wr_en  = wb_valid    && !((ZERO_REG != 0) && (wb_addr    == '0));
    assign zero1  = (ZERO_REG != 0) && (rd_addr1 == '0);
    assign zero2  = (ZERO_REG != 0) && (rd_addr2 == '0);

    busy_tracker #(.ADDR_W(ADDR_W)) u_busy (
        .clk      (clk),
        .reset    (reset),
        .set_en   (set_en),
        .set_addr (issue_addr),
        .clr_en   (wb_valid),
        .clr_addr (wb_addr),
        .busy     (busy),
        .count    (busy_cnt)
    );

    // Read-port values: zero register, optional writeback bypass, post-update busy.
    always_comb begin
        rd_next1 = regs[rd_addr1];
        rd_next2 = regs[rd_addr2];
        if (BYPASS && wb_valid && (wb_addr == rd_addr1)) rd_next1 = wb_data;
        if (BYPASS && wb_valid && (wb_addr == rd_addr2)) rd_next2 = wb_data;
        if (zero1) rd_next1 = '0;
        if (zero2) rd_next2 = '0;

        busy_next1 = busy[rd_addr1];
        busy_next2 = busy[rd_addr2];
        if (wb_valid && (wb_addr == rd_addr1)) busy_next1 = 1'b0;
        if (wb_valid && (wb_addr == rd_addr2)) busy_next2 = 1'b0;
        if (set_en && (issue_addr == rd_addr1)) busy_next1 = 1'b1;
        if (set_en && (issue_addr == rd_addr2)) busy_next2 = 1'b1;
    end

    // Register array: reset loads index values, otherwise accept writeback.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= DATA_W'(reset_value(int'(i)));
            end
        end else if (wr_en) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Registered read outputs, cleared while in reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data1 <= '0;
            rd_data2 <= '0;
            rd_busy1 <= 1'b0;
            rd_busy2 <= 1'b0;
        end else begin
            rd_data1 <= rd_next1;
            rd_data2 <= rd_next2;
            rd_busy1 <= busy_next1;
            rd_busy2 <= busy_next2;
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed vector table followed by
// randomized traffic compared against a behavioural array model.
module tb_regfile_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          rd_busy1, rd_busy2;
    logic          issue_valid;
    logic [AW-1:0] issue_addr;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic [AW:0]   busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    regfile_scoreboard dut (
        .clk         (clk),
        .reset       (reset),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .rd_busy1    (rd_busy1),
        .rd_busy2    (rd_busy2),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .busy_cnt    (busy_cnt)
    );

    typedef struct {
        logic          rst;
        logic          iv;
        logic [AW-1:0] ia;
        logic          wv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] e_d1;
        logic [DW-1:0] e_d2;
        logic          e_b1;
        logic          e_b2;
        logic [AW:0]   e_cnt;
    } vec_t;

    vec_t vecs[$];

    // ---------------- scoreboard ----------------
    logic [DW-1:0] exp_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic rst, input logic iv, input logic [AW-1:0] ia,
                         input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
        reset       = rst;
        issue_valid = iv;
        issue_addr  = ia;
        wb_valid    = wv;
        wb_addr     = wa;
        wb_data     = wd;
        rd_addr1    = ra1;
        rd_addr2    = ra2;
        @(posedge clk);
        #1;
    endtask

    // Push the five expected outputs, then pop and compare against the DUT.
    task automatic compare_outputs(input string tag, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                                   input logic b1, input logic b2, input logic [AW:0] cnt);
        exp_q.push_back(d1);
        exp_q.push_back(d2);
        exp_q.push_back(DW'(b1));
        exp_q.push_back(DW'(b2));
        exp_q.push_back(DW'(cnt));
        check({tag, ".rd_data1"}, rd_data1,       exp_q.pop_front());
        check({tag, ".rd_data2"}, rd_data2,       exp_q.pop_front());
        check({tag, ".rd_busy1"}, DW'(rd_busy1),  exp_q.pop_front());
        check({tag, ".rd_busy2"}, DW'(rd_busy2),  exp_q.pop_front());
        check({tag, ".busy_cnt"}, DW'(busy_cnt),  exp_q.pop_front());
    endtask

    task automatic add(input logic rst, input logic iv, input int ia, input logic wv, input int wa,
                       input logic [DW-1:0] wd, input int ra1, input int ra2,
                       input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                       input logic b1, input logic b2, input int cnt);
        vec_t v;
        v.rst = rst; v.iv = iv; v.ia = AW'(ia); v.wv = wv; v.wa = AW'(wa); v.wd = wd;
        v.ra1 = AW'(ra1); v.ra2 = AW'(ra2);
        v.e_d1 = d1; v.e_d2 = d2; v.e_b1 = b1; v.e_b2 = b2; v.e_cnt = (AW+1)'(cnt);
        vecs.push_back(v);
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_regs [DEPTH];
    bit            m_busy [DEPTH];

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = DW'(i);
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic random_cycle(input int cyc);
        logic          rst, iv, wv;
        logic [AW-1:0] ia, wa, ra1, ra2;
        logic [DW-1:0] wd, d1, d2;
        logic          b1, b2;
        int            cnt;
        rst = ($urandom_range(0, 39) == 0);
        iv  = $urandom_range(0, 1);
        wv  = $urandom_range(0, 1);
        ia  = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
        wa  = AW'($urandom_range(0, ($urandom_range(0, 1) != 0) ? 7 : 31));
        ra1 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 31));
        ra2 = ($urandom_range(0, 3) == 0) ? ia : AW'($urandom_range(0, 31));
        wd  = $urandom;

        if (rst) begin
            d1 = '0; d2 = '0; b1 = 1'b0; b2 = 1'b0; cnt = 0;
            model_reset();
        end else begin
            // Reads see the pre-write contents unless bypass forwards the writeback.
            d1 = (ra1 == 0) ? '0 : (BYP && wv && wa == ra1) ? wd : m_regs[ra1];
            d2 = (ra2 == 0) ? '0 : (BYP && wv && wa == ra2) ? wd : m_regs[ra2];
            if (wv) begin
                m_busy[wa] = 1'b0;
                if (wa != 0) m_regs[wa] = wd;
            end
            if (iv && ia != 0) m_busy[ia] = 1'b1;
            b1 = m_busy[ra1];
            b2 = m_busy[ra2];
            cnt = 0;
            for (int i = 0; i < DEPTH; i++) cnt += int'(m_busy[i]);
        end
        drive(rst, iv, ia, wv, wa, wd, ra1, ra2);
        compare_outputs($sformatf("rand%0d", cyc), d1, d2, b1, b2, (AW+1)'(cnt));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; issue_valid = 1'b0; issue_addr = '0; wb_valid = 1'b0;
        wb_addr = '0; wb_data = '0; rd_addr1 = '0; rd_addr2 = '0;

        //   rst iv ia wv wa wd            ra1 ra2  d1                         d2                        b1 b2 cnt
        add(1, 0, 0, 0, 0, 0,            7, 31,  0,                         0,                        0, 0, 0);
        add(0, 0, 0, 0, 0, 0,            7, 31,  7,                         31,                       0, 0, 0);
        add(0, 0, 0, 1, 0, 32'hDEADBEEF, 0, 0,   0,                         0,                        0, 0, 0);
        add(0, 0, 0, 0, 0, 0,            0, 1,   0,                         1,                        0, 0, 0);
        add(0, 1, 5, 0, 0, 0,            5, 9,   5,                         9,                        1, 0, 1);
        add(0, 1, 9, 0, 0, 0,            5, 9,   5,                         9,                        1, 1, 2);
        add(0, 0, 0, 0, 0, 0,            5, 9,   5,                         9,                        1, 1, 2);
        add(0, 0, 0, 1, 5, 32'h55,       5, 9,   BYP ? 32'h55 : 32'd5,      9,                        0, 1, 1);
        add(0, 0, 0, 0, 0, 0,            5, 9,   32'h55,                    9,                        0, 1, 1);
        add(0, 1, 12, 1, 12, 32'hAB,     12, 9,  BYP ? 32'hAB : 32'd12,     9,                        1, 1, 2);
        add(0, 0, 0, 0, 0, 0,            12, 12, 32'hAB,                    32'hAB,                   1, 1, 2);
        add(0, 0, 0, 1, 3, 32'h1234,     3, 3,   BYP ? 32'h1234 : 32'd3,    BYP ? 32'h1234 : 32'd3,   0, 0, 2);
        add(0, 0, 0, 0, 0, 0,            3, 3,   32'h1234,                  32'h1234,                 0, 0, 2);
        add(0, 1, 0, 0, 0, 0,            0, 0,   0,                         0,                        0, 0, 2);
        add(0, 1, 4, 1, 9, 32'h99,       4, 9,   4,                         BYP ? 32'h99 : 32'd9,     1, 0, 2);
        add(1, 1, 7, 1, 4, 32'hFFFF,     4, 7,   0,                         0,                        0, 0, 0);
        add(0, 0, 0, 0, 0, 0,            4, 7,   4,                         7,                        0, 0, 0);
        add(0, 0, 0, 1, 20, 32'h2020,    20, 20, BYP ? 32'h2020 : 32'd20,   BYP ? 32'h2020 : 32'd20,  0, 0, 0);
        add(0, 0, 0, 0, 0, 0,            20, 31, 32'h2020,                  31,                       0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].iv, vecs[i].ia, vecs[i].wv, vecs[i].wa, vecs[i].wd,
                  vecs[i].ra1, vecs[i].ra2);
            compare_outputs($sformatf("vec%0d", i), vecs[i].e_d1, vecs[i].e_d2,
                            vecs[i].e_b1, vecs[i].e_b2, vecs[i].e_cnt);
        end

        // Hand sequence: fill many busy bits, then reset in the middle of traffic.
        for (int a = 1; a < DEPTH; a++) drive(1'b0, 1'b1, AW'(a), 1'b0, '0, '0, '0, '0);
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 5'd31, 5'd1);
        check("all_busy.busy_cnt", DW'(busy_cnt), 32'd31);
        check("all_busy.rd_busy1", DW'(rd_busy1), 32'd1);
        drive(1'b1, 1'b1, 5'd4, 1'b0, '0, '0, '0, '0);
        drive(1'b0, 1'b0, '0, 1'b0, '0, '0, 5'd4, 5'd31);
        check("post_reset.busy_cnt", DW'(busy_cnt), 32'd0);
        check("post_reset.rd_data1", rd_data1, 32'd4);
        check("post_reset.rd_busy1", DW'(rd_busy1), 32'd0);

        // Randomized traffic against the model, starting from a clean reset.
        drive(1'b1, 1'b0, '0, 1'b0, '0, '0, '0, '0);
        model_reset();
        for (int c = 0; c < 400; c++) random_cycle(c);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, register address width; the register count is DEPTH = 2**ADDR_W.
REQ-003 The block SHALL have parameter ZERO_REG, default 1; when 1, register 0 is hardwired to zero.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 rd_addr1, rd_addr2  input  ADDR_W  read-port addresses.
REQ-007 rd_data1, rd_data2  output  DATA_W  registered read data.
REQ-008 rd_busy1, rd_busy2  output  1  registered busy flag of the addressed register.
REQ-009 issue_valid  input  1  marks issue_addr as pending (an outstanding producer exists).
REQ-010 issue_addr  input  ADDR_W  destination register being issued.
REQ-011 wb_valid  input  1  writeback strobe.
REQ-012 wb_addr  input  ADDR_W  writeback register.
REQ-013 wb_data  input  DATA_W  writeback data.
REQ-014 busy_cnt  output  ADDR_W+1  registered count of busy registers.

Function
REQ-015 Reads SHALL have 1-cycle latency: at each edge, rd_dataN <= contents of rd_addrN as defined by REQ-016/REQ-027.
REQ-016 With ZERO_REG=1, reading address 0 SHALL return 0 in all cases, including bypass.
REQ-017 When wb_valid=1 and wb_addr is not hardwired-zero, the register SHALL take wb_data at the edge.
REQ-018 wb_valid=1 SHALL clear the busy bit of wb_addr at the edge.
REQ-019 issue_valid=1 SHALL set the busy bit of issue_addr at the edge, except for address 0 when ZERO_REG=1.
REQ-020 When issue and writeback target the same address in the same cycle, set SHALL win and the busy bit SHALL remain 1, while the data is still written.
REQ-021 A writeback to a non-busy register SHALL still write the data and leave busy at 0.
REQ-022 rd_busyN SHALL reflect the busy bit after that cycle's clear and set are applied.
REQ-023 busy_cnt SHALL equal the population count of the busy bits after that cycle's update, in the range 0..DEPTH.
REQ-024 Both read ports SHALL be independent and MAY address the same register.

Reset
REQ-025 While reset=1 at an edge, register i SHALL load value i (zero-extended to DATA_W), and register 0 SHALL load 0.
REQ-026 While reset=1 at an edge, all busy bits, rd_data1, rd_data2, rd_busy1, rd_busy2 and busy_cnt SHALL be 0, and issue/writeback inputs SHALL be ignored.

Configuration
REQ-027 With macro RF_BYPASS_EN defined, a read whose address equals an active wb_addr in the same cycle SHALL return wb_data, and rd_busyN SHALL reflect the post-update flag; without the macro, the read SHALL return the pre-write value.

Structure
REQ-028 Default widths and the reset-value rule function SHALL live in shared package regfile_pkg.
REQ-029 The busy-bit vector and popcount SHALL be a sub-module named busy_tracker (ports: clk, reset, set_en, set_addr, clr_en, clr_addr, busy, count).

Verification
REQ-030 Reset then read addresses 7 and 31 -> rd_data1=7, rd_data2=31 one cycle later; busy_cnt=0.
REQ-031 Writeback to address 0 with data 0xDEADBEEF, then read 0 -> rd_data=0.
REQ-032 Issue 5 and 9; next cycle read both -> rd_busy1=rd_busy2=1, busy_cnt=2; writeback 5 with data 0x55 -> busy_cnt=1, a later read of 5 returns 0x55 with busy=0.
REQ-033 Same-cycle issue 12 and writeback 12 with data 0xAB -> busy(12)=1, data(12)=0xAB.
REQ-034 Same-cycle writeback 3 with data 0x1234 and read 3 -> returns 0x1234 with RF_BYPASS_EN defined, and 3 without it.
REQ-035 Issue 4, then assert reset mid-operation -> busy_cnt=0 and register 4 reads back 4.
